// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the multi-word carry-lookahead sequencer.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cla_multiword_sequencer_if.sv
// Handshake and operand/result bundle for cla_multiword_sequencer.
// Optional overflow flag present when CLA_SEQ_OVERFLOW_EN is defined.
interface cla_multiword_sequencer_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [N-1:0] z;
  logic         carry_out;
`ifdef CLA_SEQ_OVERFLOW_EN
  logic         overflow;
`endif

  modport master (
    output start, x, y, carry_in,
`ifdef CLA_SEQ_OVERFLOW_EN
    input  overflow,
`endif
    input  busy, done, z, carry_out
  );

  modport slave (
    input  start, x, y, carry_in,
`ifdef CLA_SEQ_OVERFLOW_EN
    output overflow,
`endif
    output busy, done, z, carry_out
  );
endinterface

// File: rtl/carry_lookahead_adder.sv
// Purely combinational WIDTH-bit carry-lookahead adder.
module carry_lookahead_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH:0]   w_c;
  logic             w_acc;
  logic             w_term;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Each carry is the flat sum-of-products of generate/propagate terms, no ripple.
  always_comb begin
    w_c    = '0;
    w_acc  = 1'b0;
    w_term = 1'b0;
    w_c[0] = i_cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_acc = i_cin;
      for (int j = 0; j <= i; j++) begin
        w_acc = w_acc & w_p[j];
      end
      for (int k = 0; k <= i; k++) begin
        w_term = w_g[k];
        for (int j = k + 1; j <= i; j++) begin
          w_term = w_term & w_p[j];
        end
        w_acc = w_acc | w_term;
      end
      w_c[i+1] = w_acc;
    end
  end

  assign o_sum  = w_p ^ w_c[WIDTH-1:0];
  assign o_cout = w_c[WIDTH];
endmodule

// File: rtl/cla_multiword_sequencer.sv
// Adds WIDTH*WORDS-bit operands one WIDTH-bit chunk per clock on a shared CLA.
// Defining CLA_SEQ_OVERFLOW_EN adds a registered two's-complement overflow flag.
module cla_multiword_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  cla_multiword_sequencer_if.slave   bus
);
  localparam int N  = WIDTH * WORDS;
  localparam int IW = (clog2(WORDS) < 1) ? 1 : clog2(WORDS);

  state_t           r_state;
  state_t           w_nextState;
  logic             w_accept;
  logic             w_lastChunk;

  logic [N-1:0]     r_x;
  logic [N-1:0]     r_y;
  logic [N-1:0]     r_z;
  logic             r_carry;
  logic             r_carryOut;
  logic [IW-1:0]    r_idx;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_lastChunk = (r_idx == IW'(WORDS - 1));

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Start is only honoured when no addition is running, so DONE can chain directly.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_nextState = ADD;
        end
      end
      ADD: begin
        if (w_lastChunk) w_nextState = DONE;
      end
      DONE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_nextState = ADD;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
    .i_a   (r_x[r_idx*WIDTH +: WIDTH]),
    .i_b   (r_y[r_idx*WIDTH +: WIDTH]),
    .i_cin (r_carry),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_carry    <= 1'b0;
      r_carryOut <= 1'b0;
      r_idx      <= '0;
    end else if (w_accept) begin
      r_x        <= bus.x;
      r_y        <= bus.y;
      r_z        <= '0;
      r_carry    <= bus.carry_in;
      r_carryOut <= 1'b0;
      r_idx      <= '0;
    end else if (r_state == ADD) begin
      r_z[r_idx*WIDTH +: WIDTH] <= w_sum;
      r_carry                   <= w_cout;
      if (w_lastChunk) r_carryOut <= w_cout;
      else             r_idx      <= r_idx + IW'(1);
    end
  end

`ifdef CLA_SEQ_OVERFLOW_EN
  logic r_overflow;

  // Top chunk's sum MSB is still on the CLA output at the last edge.
  always_ff @(posedge clock) begin
    if (reset || w_accept) begin
      r_overflow <= 1'b0;
    end else if (r_state == ADD && w_lastChunk) begin
      r_overflow <= r_x[N-1] ^ r_y[N-1] ^ w_sum[WIDTH-1] ^ w_cout;
    end
  end

  assign bus.overflow = r_overflow;
`endif

  assign bus.busy      = (r_state == ADD);
  assign bus.done      = (r_state == DONE);
  assign bus.z         = r_z;
  assign bus.carry_out = r_carryOut;
endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Directed self-checking bench for cla_multiword_sequencer (WIDTH=4, WORDS=4).
module tb_cla_multiword_sequencer;
  logic clock;
  logic reset;
  int   testsRun;
  int   testsFailed;
  int   edges;
  int   busyCycles;
  int   donePulses;

  cla_multiword_sequencer_if #(.N(16)) bus ();

  cla_multiword_sequencer #(.WIDTH(4), .WORDS(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; the first edge counted is the accept edge itself.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                               input bit disturb, output int nEdges, output int nBusy, output int nDone);
    bus.x        = a;
    bus.y        = b;
    bus.carry_in = cin;
    bus.start    = 1'b1;
    nEdges = 0;
    nBusy  = 0;
    nDone  = 0;
    while (nEdges < 20 && nDone == 0) begin
      @(posedge clock);
      nEdges++;
      @(negedge clock);
      if (nEdges == 1) begin
        checkOutput("z_cleared_on_accept", {16'h0, bus.z}, 32'h0);
        checkOutput("cout_cleared_on_accept", {31'h0, bus.carry_out}, 32'h0);
      end
      bus.start = disturb && (nEdges < 3);
      if (bus.start) begin
        bus.x        = 16'hFFFF;
        bus.y        = 16'hFFFF;
        bus.carry_in = 1'b1;
      end
      if (bus.busy) nBusy++;
      if (bus.done) nDone++;
    end
    checkOutput("done_seen", nDone, 1);
  endtask

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    bus.carry_in = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("reset_done", {31'h0, bus.done}, 32'h0);
    checkOutput("reset_z", {16'h0, bus.z}, 32'h0);
    checkOutput("reset_cout", {31'h0, bus.carry_out}, 32'h0);
`ifdef CLA_SEQ_OVERFLOW_EN
    checkOutput("reset_overflow", {31'h0, bus.overflow}, 32'h0);
`endif
    reset = 1'b0;
    @(negedge clock);

    // Test 1: carry crosses from chunk 1 into chunk 2
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, edges, busyCycles, donePulses);
    checkOutput("t1_z", {16'h0, bus.z}, 32'h0100);
    checkOutput("t1_cout", {31'h0, bus.carry_out}, 32'h0);
    checkOutput("t1_latency", edges, 5);
    checkOutput("t1_busy_cycles", busyCycles, 4);
    @(negedge clock);
    checkOutput("t1_done_single", {31'h0, bus.done}, 32'h0);
    checkOutput("t1_z_held", {16'h0, bus.z}, 32'h0100);

    // Test 2: carry_in ripples through every chunk
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0, edges, busyCycles, donePulses);
    checkOutput("t2_z", {16'h0, bus.z}, 32'h0000);
    checkOutput("t2_cout", {31'h0, bus.carry_out}, 32'h1);
    @(negedge clock);

    // Test 3: start while busy is ignored
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b1, edges, busyCycles, donePulses);
    checkOutput("t3_z", {16'h0, bus.z}, 32'h2345);
    checkOutput("t3_cout", {31'h0, bus.carry_out}, 32'h0);
    checkOutput("t3_latency", edges, 5);
    @(negedge clock);
    checkOutput("t3_done_single", {31'h0, bus.done}, 32'h0);
    checkOutput("t3_idle", {31'h0, bus.busy}, 32'h0);

    // Test 4: reset in the second ADD cycle
    bus.x        = 16'h1234;
    bus.y        = 16'h1111;
    bus.carry_in = 1'b0;
    bus.start    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("t4_busy_before_reset", {31'h0, bus.busy}, 32'h1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("t4_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("t4_done", {31'h0, bus.done}, 32'h0);
    checkOutput("t4_z", {16'h0, bus.z}, 32'h0);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, edges, busyCycles, donePulses);
    checkOutput("t4_z_after", {16'h0, bus.z}, 32'h0002);
    @(negedge clock);

    // Test 5: back-to-back start in the DONE cycle
    applyStimulus(16'h0F0F, 16'hF0F0, 1'b0, 1'b0, edges, busyCycles, donePulses);
    checkOutput("t5_first_z", {16'h0, bus.z}, 32'hFFFF);
    checkOutput("t5_first_done", {31'h0, bus.done}, 32'h1);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, edges, busyCycles, donePulses);
    checkOutput("t5_second_z", {16'h0, bus.z}, 32'h0000);
    checkOutput("t5_second_cout", {31'h0, bus.carry_out}, 32'h1);
    checkOutput("t5_latency", edges, 5);
    checkOutput("t5_busy_cycles", busyCycles, 4);
    @(negedge clock);

`ifdef CLA_SEQ_OVERFLOW_EN
    // Test 6: signed overflow flag
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, edges, busyCycles, donePulses);
    checkOutput("t6a_z", {16'h0, bus.z}, 32'h8000);
    checkOutput("t6a_ovf", {31'h0, bus.overflow}, 32'h1);
    @(negedge clock);
    applyStimulus(16'h8000, 16'hFFFF, 1'b0, 1'b0, edges, busyCycles, donePulses);
    checkOutput("t6b_z", {16'h0, bus.z}, 32'h7FFF);
    checkOutput("t6b_ovf", {31'h0, bus.overflow}, 32'h1);
    checkOutput("t6b_cout", {31'h0, bus.carry_out}, 32'h1);
    @(negedge clock);
    applyStimulus(16'h0003, 16'h0004, 1'b0, 1'b0, edges, busyCycles, donePulses);
    checkOutput("t6c_z", {16'h0, bus.z}, 32'h0007);
    checkOutput("t6c_ovf", {31'h0, bus.overflow}, 32'h0);
    @(negedge clock);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
